// File: rtl/dma_fpram_wr_pkg.sv
// ============================================================================
// dma_fpram_wr_pkg : shared constants and state encoding for the FPRAM DMA
// write engine.  Rev 1.0
// ============================================================================
`default_nettype none

package dma_fpram_wr_pkg;

   localparam int FPRAM_AW = 8;
   localparam int FPRAM_DW = 16;

   localparam logic TGT_CRAM  = 1'b0;
   localparam logic TGT_SFILE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

endpackage : dma_fpram_wr_pkg

`default_nettype wire

// File: rtl/dma_fpram_wr.sv
// ============================================================================
// dma_fpram_wr : DMA write engine turning a 16-bit source stream into
// one-cycle CRAM / SFILE write strokes.  Rev 1.0
// ============================================================================
`default_nettype none

module dma_fpram_wr
   import dma_fpram_wr_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                tgt,
   input  logic [FPRAM_AW-1:0] addr_init,
   input  logic [8:0]          len,
   input  logic                abort,
   input  logic [FPRAM_DW-1:0] src_data,
   input  logic                src_valid,
   output logic                src_ready,
   output logic [FPRAM_DW-1:0] dma_data,
   output logic [FPRAM_AW-1:0] dma_wraddr,
   output logic                dma_cram_we,
   output logic                dma_sfile_we,
   output logic                busy,
   output logic                done
);

   state_e              state_q;
   logic [FPRAM_AW-1:0] addr_cnt_q;
   logic [8:0]          rem_q;
   logic                tgt_q;
   logic [FPRAM_DW-1:0] data_q;
   logic [FPRAM_AW-1:0] wraddr_q;
   logic                cram_we_q;
   logic                sfile_we_q;
   logic                hs;

   // abort masks ready so no word is consumed in the cycle the burst is killed
   assign src_ready = (state_q == ST_RUN) && !abort;
   assign hs        = src_ready && src_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_cnt_q <= '0;
         rem_q      <= '0;
         tgt_q      <= TGT_CRAM;
         data_q     <= '0;
         wraddr_q   <= '0;
         cram_we_q  <= 1'b0;
         sfile_we_q <= 1'b0;
      end else begin
         cram_we_q  <= hs && (tgt_q == TGT_CRAM);
         sfile_we_q <= hs && (tgt_q == TGT_SFILE);
         if (hs) begin
            data_q     <= src_data;
            wraddr_q   <= addr_cnt_q;
            addr_cnt_q <= addr_cnt_q + 8'd1;
            rem_q      <= rem_q - 9'd1;
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (len != 9'd0) begin
                     addr_cnt_q <= addr_init;
                     rem_q      <= len;
                     tgt_q      <= tgt;
                     state_q    <= ST_RUN;
                  end else begin
                     state_q <= ST_FIN;
                  end
               end
            end
            ST_RUN: begin
               if (hs && (rem_q == 9'd1)) begin
                  state_q <= ST_FIN;
               end else if (abort) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_FIN:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign dma_data     = data_q;
   assign dma_wraddr   = wraddr_q;
   assign dma_cram_we  = cram_we_q;
   assign dma_sfile_we = sfile_we_q;
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_FIN);

endmodule : dma_fpram_wr

`default_nettype wire

// File: tb/tb_dma_fpram_wr.sv
// ============================================================================
// tb_dma_fpram_wr : randomized and directed bench for dma_fpram_wr against a
// burst-level reference model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_dma_fpram_wr;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        tgt;
   logic [7:0]  addr_init;
   logic [8:0]  len;
   logic        abort;
   logic [15:0] src_data;
   logic        src_valid;
   logic        src_ready;
   logic [15:0] dma_data;
   logic [7:0]  dma_wraddr;
   logic        dma_cram_we;
   logic        dma_sfile_we;
   logic        busy;
   logic        done;

   dma_fpram_wr dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .tgt         (tgt),
      .addr_init   (addr_init),
      .len         (len),
      .abort       (abort),
      .src_data    (src_data),
      .src_valid   (src_valid),
      .src_ready   (src_ready),
      .dma_data    (dma_data),
      .dma_wraddr  (dma_wraddr),
      .dma_cram_we (dma_cram_we),
      .dma_sfile_we(dma_sfile_we),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Burst-level reference model
   bit          m_run, m_fin, m_tgt, m_we_c, m_we_s;
   int          m_rem, m_next, m_burst_hs;
   logic [15:0] m_data;
   logic [7:0]  m_addr;
   bit          rst_seen = 0;

   typedef struct {
      int          cyc;
      logic [7:0]  a;
      logic [15:0] d;
      logic        t;
   } wr_t;
   wr_t obs[$];
   int  cyc = 0;
   int  done_cnt, busy_cnt, done_widx;
   bit  rand_data;

   always @(posedge rst) rst_seen = 1;

   initial begin : compare
      bit hs;
      forever begin
         @(posedge clk);
         if (rst || rst_seen) begin
            m_run = 0; m_fin = 0; m_we_c = 0; m_we_s = 0;
            m_data = '0; m_addr = '0; m_rem = 0; m_next = 0;
            rst_seen = 0;
         end else begin
            hs = m_run && !abort && src_valid;
            m_we_c = hs && !m_tgt;
            m_we_s = hs && m_tgt;
            if (hs) begin
               m_data = src_data;
               m_addr = 8'(m_next);
               m_next = (m_next + 1) % 256;
               m_rem--;
               m_burst_hs++;
            end
            if (m_fin) m_fin = 0;
            else if (m_run) begin
               if (hs && m_rem == 0) begin m_run = 0; m_fin = 1; end
               else if (abort) m_run = 0;
            end else if (start) begin
               m_burst_hs = 0;
               if (len == 0) m_fin = 1;
               else begin
                  m_run = 1; m_next = int'(addr_init); m_rem = int'(len); m_tgt = tgt;
               end
            end
         end
         @(negedge clk);
         #1;
         cyc++;
         chk("src_ready",    src_ready,    m_run && !abort);
         chk("busy",         busy,         m_run || m_fin);
         chk("done",         done,         m_fin);
         chk("dma_cram_we",  dma_cram_we,  m_we_c);
         chk("dma_sfile_we", dma_sfile_we, m_we_s);
         chk("dma_data",     dma_data,     m_data);
         chk("dma_wraddr",   dma_wraddr,   m_addr);
         if (dma_cram_we || dma_sfile_we)
            obs.push_back('{cyc: cyc, a: dma_wraddr, d: dma_data, t: dma_sfile_we});
         if (busy) busy_cnt++;
         if (done) begin done_cnt++; done_widx = obs.size(); end
      end
   end

   task automatic drive(input logic s, input logic v, input logic a);
      @(negedge clk);
      start     = s;
      src_valid = v;
      abort     = a;
      src_data  = rand_data ? 16'($urandom) : 16'(16'h1111 * (m_burst_hs + 1));
   endtask

   task automatic clr();
      obs.delete();
      done_cnt = 0; busy_cnt = 0; done_widx = -1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0);
   endtask

   initial begin : stim
      bit         seen[256];
      int         nseen;
      logic [7:0] a0;
      rst = 1'b1; start = 0; tgt = 0; addr_init = 0; len = 0; abort = 0;
      src_data = 0; src_valid = 0; rand_data = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(2);

      // CRAM burst
      clr(); tgt = 0; addr_init = 8'h10; len = 9'd4; rand_data = 0;
      drive(1, 1, 0); repeat (6) drive(0, 1, 0); idle(3);
      chk("cram_nwr", obs.size(), 4);
      for (int i = 0; i < 4 && i < obs.size(); i++) begin
         chk("cram_addr", obs[i].a, 8'h10 + 8'(i));
         chk("cram_data", obs[i].d, 16'(16'h1111 * (i + 1)));
         chk("cram_tgt",  obs[i].t, 1'b0);
      end
      chk("cram_done_cnt", done_cnt, 1);
      chk("cram_done_at",  done_widx, 4);
      chk("cram_busy_len", busy_cnt, 5);

      // SFILE wrap
      clr(); tgt = 1; addr_init = 8'hFE; len = 9'd3;
      drive(1, 1, 0); repeat (5) drive(0, 1, 0); idle(3);
      chk("wrap_nwr", obs.size(), 3);
      for (int i = 0; i < 3 && i < obs.size(); i++) begin
         chk("wrap_addr", obs[i].a, 8'(8'hFE + i));
         chk("wrap_tgt",  obs[i].t, 1'b1);
      end

      // Throttled source
      clr(); tgt = 0; addr_init = 8'h40; len = 9'd3; rand_data = 1;
      drive(1, 0, 0);
      drive(0, 1, 0); drive(0, 0, 0); drive(0, 0, 0);
      drive(0, 1, 0); drive(0, 0, 0); drive(0, 1, 0);
      idle(4);
      chk("thr_nwr", obs.size(), 3);
      if (obs.size() == 3) begin
         chk("thr_addr1", obs[1].a, 8'h41);
         chk("thr_addr2", obs[2].a, 8'h42);
         chk("thr_gap1",  obs[1].cyc - obs[0].cyc, 3);
         chk("thr_gap2",  obs[2].cyc - obs[0].cyc, 5);
      end

      // Abort after third handshake
      clr(); tgt = 1; addr_init = 8'h80; len = 9'd8;
      drive(1, 1, 0); repeat (3) drive(0, 1, 0); drive(0, 1, 1);
      repeat (4) drive(0, 1, 0); idle(3);
      chk("abort_nwr",  obs.size(), 3);
      chk("abort_done", done_cnt, 0);
      chk("abort_busy", busy_cnt, 4);

      // start+abort in IDLE, abort during FIN
      clr(); tgt = 0; addr_init = 8'h05; len = 9'd1;
      drive(1, 1, 1); drive(0, 1, 0); drive(0, 0, 1); idle(3);
      chk("fin_nwr",  obs.size(), 1);
      chk("fin_done", done_cnt, 1);
      chk("fin_busy", busy_cnt, 2);

      // Zero length
      clr(); len = 9'd0;
      drive(1, 1, 0); idle(3);
      chk("zero_nwr",  obs.size(), 0);
      chk("zero_done", done_cnt, 1);
      chk("zero_busy", busy_cnt, 1);

      // Full 256-word burst with an ignored restart
      clr(); tgt = 1'($urandom); a0 = 8'($urandom); addr_init = a0; len = 9'd256;
      drive(1, 1, 0); repeat (10) drive(0, 1, 0);
      len = 9'd5; addr_init = 8'h00; tgt = ~tgt;
      drive(1, 1, 0); repeat (250) drive(0, 1, 0); idle(3);
      chk("full_nwr",  obs.size(), 256);
      chk("full_done", done_cnt, 1);
      foreach (seen[i]) seen[i] = 0;
      nseen = 0;
      foreach (obs[i]) if (!seen[obs[i].a]) begin seen[obs[i].a] = 1; nseen++; end
      chk("full_cover", nseen, 256);
      if (obs.size() > 0) chk("full_first", obs[0].a, a0);

      // Randomized traffic
      repeat (12) begin
         int n;
         tgt = 1'($urandom); addr_init = 8'($urandom);
         len = ($urandom_range(0, 9) == 0) ? 9'd0 : 9'($urandom_range(1, 24));
         drive(1, 1'($urandom), 0);
         n = 3 * int'(len) + 4;
         repeat (n) begin
            tgt = 1'($urandom); addr_init = 8'($urandom); len = 9'($urandom_range(0, 24));
            drive(1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom_range(0, 39) == 0));
         end
         idle(3);
      end

      // Asynchronous reset mid-burst
      clr(); tgt = 0; addr_init = 8'h20; len = 9'd20;
      drive(1, 1, 0); repeat (5) drive(0, 1, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_ready", src_ready, 1'b0);
      chk("arst_cwe",   dma_cram_we, 1'b0);
      chk("arst_swe",   dma_sfile_we, 1'b0);
      chk("arst_busy",  busy, 1'b0);
      chk("arst_done",  done, 1'b0);
      chk("arst_data",  dma_data, 16'h0);
      chk("arst_addr",  dma_wraddr, 8'h0);
      #1 rst = 1'b0;
      repeat (4) drive(0, 1, 0);
      idle(2);
      chk("arst_done_cnt", done_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_dma_fpram_wr

`default_nettype wire
